// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor. On an accepted start the operands are
//   captured and processed LSB first, one bit per clock, through a single
//   full-subtractor cell. After WIDTH bits the difference and the final borrow
//   are loaded into D/Bout and done pulses for one cycle.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; operands are captured on the accepting edge
//   RUN   | one bit per cycle, LSB first, for WIDTH cycles; busy=1
//   DONE  | result valid on D/Bout; done=1 for this single cycle
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   start : begin a subtraction (only looked at in IDLE)
//   A, B  : minuend / subtrahend, captured when start is accepted
//   busy  : high while in RUN
//   done  : one-cycle pulse, result valid
//   D     : A-B modulo 2^WIDTH, held until the next completion or reset
//   Bout  : final borrow out (A < B unsigned)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_nxt;
    logic             bin;
    logic [CW-1:0]    cnt;

    logic             a_bit;
    logic             b_bit;
    logic             diff_bit;
    logic             bout_bit;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs.
    assign a_bit    = a_sr[0];
    assign b_bit    = b_sr[0];
    assign diff_bit = a_bit ^ b_bit ^ bin;
    assign bout_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
    assign last_bit = (cnt == LAST);

    // New diff bit enters from the MSB side; the oldest bit drops off the LSB.
    // After WIDTH shifts the first (LSB) diff bit lands in position 0.
    assign r_nxt = WIDTH'({diff_bit, r_sr} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            r_sr <= '0;
            bin  <= 1'b0;
            cnt  <= '0;
            D    <= '0;
            Bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= A;
                        b_sr <= B;
                        r_sr <= '0;
                        bin  <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_nxt;
                    bin  <= bout_bit;
                    cnt  <= cnt + CW'(1);
                    // D/Bout only change on the final bit so they stay
                    // stable for the whole run.
                    if (last_bit) begin
                        D    <= r_nxt;
                        Bout <= bout_bit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Drives a WIDTH=4 and a WIDTH=8 instance. A cycle-level reference model
//   (remaining-cycle countdown plus plain integer subtraction) predicts
//   busy/done/D/Bout; one negedge process compares both instances every cycle
//   and, for directed operations, also checks literal results and latency.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4;
    logic       done4;
    logic [3:0] d4;
    logic       bout4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8;
    logic       done8;
    logic [7:0] d8;
    logic       bout8;

    serial_subtractor #(.WIDTH(4)) u_sub4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .A     (a4),
        .B     (b4),
        .busy  (busy4),
        .done  (done4),
        .D     (d4),
        .Bout  (bout4)
    );

    serial_subtractor #(.WIDTH(8)) u_sub8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .busy  (busy8),
        .done  (done8),
        .D     (d8),
        .Bout  (bout8)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    int         run4 = 0;
    logic       done_e4 = 1'b0;
    logic [3:0] d_e4 = '0;
    logic       b_e4 = 1'b0;
    logic [3:0] pd4 = '0;
    logic       pb4 = 1'b0;

    int         run8 = 0;
    logic       done_e8 = 1'b0;
    logic [7:0] d_e8 = '0;
    logic       b_e8 = 1'b0;
    logic [7:0] pd8 = '0;
    logic       pb8 = 1'b0;

    always @(posedge clk) begin
        int diff;
        if (rst) begin
            run4 = 0; done_e4 = 1'b0; d_e4 = '0; b_e4 = 1'b0;
        end else if (done_e4) begin
            done_e4 = 1'b0;
        end else if (run4 > 0) begin
            run4 = run4 - 1;
            if (run4 == 0) begin
                done_e4 = 1'b1; d_e4 = pd4; b_e4 = pb4;
            end
        end else if (start4) begin
            diff = int'(a4) - int'(b4);
            pd4  = 4'(diff & 15);
            pb4  = (diff < 0);
            run4 = 4;
        end

        if (rst) begin
            run8 = 0; done_e8 = 1'b0; d_e8 = '0; b_e8 = 1'b0;
        end else if (done_e8) begin
            done_e8 = 1'b0;
        end else if (run8 > 0) begin
            run8 = run8 - 1;
            if (run8 == 0) begin
                done_e8 = 1'b1; d_e8 = pd8; b_e8 = pb8;
            end
        end else if (start8) begin
            diff = int'(a8) - int'(b8);
            pd8  = 8'(diff & 255);
            pb8  = (diff < 0);
            run8 = 8;
        end
    end

    // ---------------- literal expectations for directed ops ----------------
    logic        chk_en = 1'b0;
    logic        lit4_arm = 1'b0;
    logic [3:0]  lit4_d = '0;
    logic        lit4_b = 1'b0;
    int unsigned lit4_t0 = 0;
    logic        lit8_arm = 1'b0;
    logic [7:0]  lit8_d = '0;
    logic        lit8_b = 1'b0;
    int unsigned lit8_t0 = 0;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: actual %0d, expected %0d", nm, cyc, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy4", 32'(busy4), 32'(run4 > 0));
            check("done4", 32'(done4), 32'(done_e4));
            check("D4",    32'(d4),    32'(d_e4));
            check("Bout4", 32'(bout4), 32'(b_e4));
            check("busy8", 32'(busy8), 32'(run8 > 0));
            check("done8", 32'(done8), 32'(done_e8));
            check("D8",    32'(d8),    32'(d_e8));
            check("Bout8", 32'(bout8), 32'(b_e8));
            if (done4 && lit4_arm) begin
                check("latency4",   32'(cyc - lit4_t0), 32'd4);
                check("D4_lit",     32'(d4),    32'(lit4_d));
                check("Bout4_lit",  32'(bout4), 32'(lit4_b));
                check("model4_lit", 32'({b_e4, d_e4}), 32'({lit4_b, lit4_d}));
            end
            if (done8 && lit8_arm) begin
                check("latency8",   32'(cyc - lit8_t0), 32'd8);
                check("D8_lit",     32'(d8),    32'(lit8_d));
                check("Bout8_lit",  32'(bout8), 32'(lit8_b));
                check("model8_lit", 32'({b_e8, d_e8}), 32'({lit8_b, lit8_d}));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called at posedge+2 with the WIDTH=4 instance idle; returns with it idle.
    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ed, input logic eb);
        a4 = a; b4 = b; start4 = 1'b1;
        lit4_d = ed; lit4_b = eb; lit4_t0 = cyc + 1; lit4_arm = 1'b1;
        tick();
        start4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        repeat (5) tick();
        lit4_arm = 1'b0;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb);
        a8 = a; b8 = b; start8 = 1'b1;
        lit8_d = ed; lit8_b = eb; lit8_t0 = cyc + 1; lit8_arm = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        repeat (9) tick();
        lit8_arm = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        // Start issued together with reset release: accepted on the first edge.
        rst = 1'b0;
        op4(4'd9, 4'd3, 4'd6,  1'b0);
        op4(4'd3, 4'd9, 4'd10, 1'b1);
        op4(4'd0, 4'd1, 4'd15, 1'b1);
        op4(4'd7, 4'd7, 4'd0,  1'b0);
        op4(4'd0, 4'd15, 4'd1, 1'b1);

        // Re-pulse start with new operands during RUN and during DONE.
        a4 = 4'd9; b4 = 4'd3; start4 = 1'b1;
        lit4_d = 4'd6; lit4_b = 1'b0; lit4_t0 = cyc + 1; lit4_arm = 1'b1;
        tick();
        a4 = 4'd1; b4 = 4'd14;
        tick();
        start4 = 1'b0;
        repeat (3) tick();
        a4 = 4'd2; b4 = 4'd11; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lit4_arm = 1'b0;
        tick();

        // Reset on the second RUN cycle, then an immediate fresh start.
        a4 = 4'd9; b4 = 4'd3; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        op4(4'd12, 4'd5, 4'd7, 1'b0);

        op8(8'd200, 8'd55, 8'd145, 1'b0);
        op8(8'd0,   8'd255, 8'd1,  1'b1);
        op8(8'd128, 8'd129, 8'd255, 1'b1);

        // Random traffic on both instances, including held starts and resets.
        for (int i = 0; i < 1500; i++) begin
            start4 = ($urandom_range(0, 2) == 0);
            a4     = 4'($urandom);
            b4     = 4'($urandom);
            start8 = ($urandom_range(0, 2) == 0);
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            rst    = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
